llc_req_arbiter: RTL and testbench
==================================

LLC_REQ_ARBITER -- requirements
Module: llc_req_arbiter

Interface
REQ-001 SHALL have parameter MAX_STREAK, default 4: maximum consecutive grants to one of req/dma while the other is valid.
REQ-002 SHALL have parameter MAX_INFLIGHT, default 4: maximum transactions admitted to the LLC pipeline and not yet retired.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 llc_rst_tb_valid / llc_rsp_in_valid / llc_req_in_valid / llc_dma_req_in_valid  in  1 each  channel request.
REQ-006 llc_rst_tb_ready / llc_rsp_in_ready / llc_req_in_ready / llc_dma_req_in_ready  out  1 each  channel accepted this cycle.
REQ-007 req_stall / dma_stall / rst_stall  in  1 each  block the req, dma and rst_tb channels respectively.
REQ-008 drain_req  in  1  level request to stop admission and empty the pipeline.
REQ-009 pipe_done  in  1  one-cycle pulse; one admitted transaction retired (UPDATE exit).
REQ-010 arb_valid  out  1  grant record valid toward the decode FIFO.
REQ-011 arb_ready  in  1  decode FIFO can accept (not full).
REQ-012 arb_sel  out  4  one-hot grant {dma, req, rsp, rst_tb}, bit 0 = rst_tb.
REQ-013 drain_done  out  1  drain complete: pipeline empty and no grant held.
REQ-014 inflight  out  3  current admitted-not-retired count.

Function
REQ-015 Channel eligibility SHALL be: rst_tb requires !rst_stall; rsp is always eligible; req requires !req_stall; dma requires !dma_stall.
REQ-016 Fixed priority SHALL be rst_tb > rsp > {req, dma}; req and dma SHALL share the lowest level.
REQ-017 Between req and dma, the last-granted one SHALL win while its streak counter < MAX_STREAK.
REQ-018 When the streak counter reaches MAX_STREAK and the other channel is eligible, the other channel SHALL win and the counter SHALL reset to 1.
REQ-019 A grant to rst_tb or rsp SHALL NOT change the req/dma streak state.
REQ-020 The state machine SHALL have states IDLE, HOLD and DRAIN.
REQ-021 IDLE: on an eligible channel with admission allowed, SHALL pulse that channel's ready for one cycle, load arb_sel and go to HOLD.
REQ-022 Admission SHALL be allowed when inflight < MAX_INFLIGHT and drain_req = 0.
REQ-023 Input-to-arb_valid latency SHALL be one cycle.
REQ-024 HOLD: arb_valid = 1 and arb_sel SHALL stay stable until arb_valid & arb_ready.
REQ-025 On that HOLD handshake, if a new grant is allowed the same cycle, the block SHALL reload and stay in HOLD (one grant per cycle sustained); else it SHALL go to IDLE.
REQ-026 At most one input ready SHALL be high per cycle, and never while a held grant is not being handshaken.
REQ-027 inflight SHALL increment on arb_valid & arb_ready and decrement on pipe_done; both in the same cycle SHALL leave it unchanged.
REQ-028 pipe_done with inflight = 0 SHALL be ignored (saturate at 0).
REQ-029 On drain_req, the block SHALL enter DRAIN from IDLE, or from HOLD after the pending handshake completes.
REQ-030 DRAIN: no readies SHALL be asserted; drain_done = 1 when inflight = 0; on drain_req = 0 the block SHALL return to IDLE.
REQ-031 Deasserting a stall input SHALL NOT affect an already-held grant.

Reset
REQ-032 On rst low: state = IDLE; arb_valid = 0; arb_sel = 0; all readies = 0; inflight = 0; drain_done = 0; streak = 0; last-winner = req.
REQ-033 Reset asserted mid-HOLD SHALL discard the held grant without a handshake.

Structure
REQ-034 The arbiter state enum and the channel-index constants (ARB_RST_TB = 0 … ARB_DMA = 3) SHALL be placed in the shared cache package.
REQ-035 The req/dma fairness logic (streak counter plus last-winner flag) SHALL be one sub-module, llc_rr_streak.
REQ-036 Only this block SHALL drive the LLC input-channel readies; the input decoder SHALL consume arb_sel.

Verification
REQ-037 Bench SHALL cover: all four valid, no stalls, arb_ready = 1 -> grants rst_tb, rsp, then req/dma alternation; one grant per cycle after the first.
REQ-038 Bench SHALL cover: req and dma both continuously valid, MAX_STREAK = 4 -> pattern req×4, dma×4, req×4.
REQ-039 Bench SHALL cover: arb_ready held 0 for 5 cycles after a grant -> arb_sel stable; no input ready for those 5 cycles.
REQ-040 Bench SHALL cover: 4 admissions, no pipe_done -> 5th valid request not readied; one pipe_done -> admitted next cycle.
REQ-041 Bench SHALL cover: drain_req with inflight = 2, then two pipe_done pulses -> drain_done = 1 only after the second pulse.
REQ-042 Bench SHALL cover: reset asserted in HOLD with inflight = 3 -> arb_valid = 0 and inflight = 0 immediately; no ready on release until inputs are re-evaluated.

Source files
------------

// File: rtl/llc_req_arbiter_pkg.sv
// llc_req_arbiter_pkg: shared arbiter state encoding and LLC input-channel indices
package llc_req_arbiter_pkg;
   typedef enum logic [1:0] {ARB_IDLE, ARB_HOLD, ARB_DRAIN} arb_state_t;
   localparam int ARB_RST_TB = 0;
   localparam int ARB_RSP    = 1;
   localparam int ARB_REQ    = 2;
   localparam int ARB_DMA    = 3;
endpackage

// File: rtl/llc_req_arbiter_rr_streak.sv
// llc_rr_streak: req/dma fairness; the last winner keeps winning for up to MAX_STREAK grants in a row
module llc_rr_streak #(
   parameter int MAX_STREAK = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic req_elig,
   input  logic dma_elig,
   input  logic fire,
   output logic pick_dma
);
   localparam int SW = $clog2(MAX_STREAK + 1);
   localparam logic [SW-1:0] SMAX = SW'(MAX_STREAK);
   logic [SW-1:0] streak;
   logic last_dma;
   logic capped;
   always_comb begin
      capped = streak >= SMAX;
      pick_dma = (req_elig && dma_elig) ? (last_dma ^ capped) : dma_elig;
   end
   // streak saturates when the last winner keeps winning because the other side is idle
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         streak <= '0;
         last_dma <= 1'b0;
      end else if (fire) begin
         last_dma <= pick_dma;
         streak <= (pick_dma != last_dma) ? SW'(1) : (capped ? streak : streak + 1'b1);
      end
endmodule

// File: rtl/llc_req_arbiter.sv
// llc_req_arbiter: admits one LLC input channel per cycle into the pipeline,
// bounded by an in-flight limit, with a drain mode that stops admission.
module llc_req_arbiter
   import llc_req_arbiter_pkg::*;
#(
   parameter int MAX_STREAK   = 4,
   parameter int MAX_INFLIGHT = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       llc_rst_tb_valid,
   input  logic       llc_rsp_in_valid,
   input  logic       llc_req_in_valid,
   input  logic       llc_dma_req_in_valid,
   output logic       llc_rst_tb_ready,
   output logic       llc_rsp_in_ready,
   output logic       llc_req_in_ready,
   output logic       llc_dma_req_in_ready,
   input  logic       req_stall,
   input  logic       dma_stall,
   input  logic       rst_stall,
   input  logic       drain_req,
   input  logic       pipe_done,
   output logic       arb_valid,
   input  logic       arb_ready,
   output logic [3:0] arb_sel,
   output logic       drain_done,
   output logic [2:0] inflight
);
   arb_state_t state, state_nxt;
   logic [3:0] elig, grant;
   logic hs, admit, may, pick_dma;
   assign elig = {llc_dma_req_in_valid & ~dma_stall, llc_req_in_valid & ~req_stall,
                  llc_rsp_in_valid, llc_rst_tb_valid & ~rst_stall};
   assign hs = arb_valid & arb_ready;
   // the held grant already counts against the in-flight limit
   assign admit = (({1'b0, inflight} + {3'b0, arb_valid}) < 4'(MAX_INFLIGHT)) && !drain_req;
   llc_rr_streak #(.MAX_STREAK(MAX_STREAK)) u_streak (
      .clk(clk),
      .rst(rst),
      .req_elig(elig[ARB_REQ]),
      .dma_elig(elig[ARB_DMA]),
      .fire(grant[ARB_REQ] | grant[ARB_DMA]),
      .pick_dma(pick_dma)
   );
   always_comb begin
      may = rst && admit && (state == ARB_IDLE || (state == ARB_HOLD && arb_ready));
      grant = !may ? 4'b0000 :
              elig[ARB_RST_TB] ? 4'b0001 :
              elig[ARB_RSP] ? 4'b0010 :
              (elig[ARB_REQ] | elig[ARB_DMA]) ? (pick_dma ? 4'b1000 : 4'b0100) : 4'b0000;
      state_nxt = state;
      if (|grant)
         state_nxt = ARB_HOLD;
      else if (state != ARB_HOLD || hs)
         state_nxt = drain_req ? ARB_DRAIN : ARB_IDLE;
   end
   assign {llc_dma_req_in_ready, llc_req_in_ready, llc_rsp_in_ready, llc_rst_tb_ready} = grant;
   assign arb_valid = state == ARB_HOLD;
   assign drain_done = state == ARB_DRAIN && inflight == 3'd0;
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state <= ARB_IDLE;
         arb_sel <= '0;
         inflight <= '0;
      end else begin
         state <= state_nxt;
         if (!arb_valid || hs)
            arb_sel <= grant;
         inflight <= inflight + 3'(hs) - 3'(pipe_done && inflight != 3'd0);
      end
endmodule

// File: tb/tb_llc_req_arbiter.sv
// tb_llc_req_arbiter: directed spec scenarios plus random traffic, all checked
// against a cycle-level transaction model of the arbiter rules.
module tb_llc_req_arbiter;
   localparam int MAX_STREAK = 4;
   localparam int MAX_INFLIGHT = 4;
   logic clk = 1'b0;
   logic rst;
   logic llc_rst_tb_valid, llc_rsp_in_valid, llc_req_in_valid, llc_dma_req_in_valid;
   logic llc_rst_tb_ready, llc_rsp_in_ready, llc_req_in_ready, llc_dma_req_in_ready;
   logic req_stall, dma_stall, rst_stall, drain_req, pipe_done, arb_valid, arb_ready, drain_done;
   logic [3:0] arb_sel;
   logic [2:0] inflight;
   int n_chk = 0;
   int n_err = 0;
   int m_hold, m_infl, m_last, m_streak;
   bit m_drain;
   logic [3:0] rdy_seen;
   logic dd_seen;
   always #5 clk = ~clk;
   llc_req_arbiter #(.MAX_STREAK(MAX_STREAK), .MAX_INFLIGHT(MAX_INFLIGHT)) dut (
      .clk(clk), .rst(rst),
      .llc_rst_tb_valid(llc_rst_tb_valid), .llc_rsp_in_valid(llc_rsp_in_valid),
      .llc_req_in_valid(llc_req_in_valid), .llc_dma_req_in_valid(llc_dma_req_in_valid),
      .llc_rst_tb_ready(llc_rst_tb_ready), .llc_rsp_in_ready(llc_rsp_in_ready),
      .llc_req_in_ready(llc_req_in_ready), .llc_dma_req_in_ready(llc_dma_req_in_ready),
      .req_stall(req_stall), .dma_stall(dma_stall), .rst_stall(rst_stall),
      .drain_req(drain_req), .pipe_done(pipe_done),
      .arb_valid(arb_valid), .arb_ready(arb_ready), .arb_sel(arb_sel),
      .drain_done(drain_done), .inflight(inflight)
   );
   function automatic logic [3:0] readies();
      return {llc_dma_req_in_ready, llc_req_in_ready, llc_rsp_in_ready, llc_rst_tb_ready};
   endfunction
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask
   task automatic set_in(input logic v0, input logic v1, input logic v2, input logic v3);
      {llc_rst_tb_valid, llc_rsp_in_valid, llc_req_in_valid, llc_dma_req_in_valid} = {v0, v1, v2, v3};
   endtask
   task automatic model_reset();
      m_hold = -1;
      m_infl = 0;
      m_drain = 0;
      m_last = 2;
      m_streak = 0;
   endtask
   // called at a falling edge with inputs already driven; checks, advances the model, waits one cycle
   task automatic step();
      logic [3:0] el, exp_rdy;
      int w, sel;
      bit hs, may;
      #1;
      el = {llc_dma_req_in_valid & ~dma_stall, llc_req_in_valid & ~req_stall,
            llc_rsp_in_valid, llc_rst_tb_valid & ~rst_stall};
      w = -1;
      if (el[0]) w = 0;
      else if (el[1]) w = 1;
      else if (el[2] && el[3]) w = (m_streak < MAX_STREAK) ? m_last : 5 - m_last;
      else if (el[2]) w = 2;
      else if (el[3]) w = 3;
      hs = m_hold >= 0 && arb_ready;
      may = !m_drain && !drain_req && (m_hold < 0 || arb_ready) &&
            (m_infl + ((m_hold >= 0) ? 1 : 0)) < MAX_INFLIGHT;
      exp_rdy = (may && w >= 0) ? 4'(1 << w) : 4'b0000;
      sel = (m_hold >= 0) ? (1 << m_hold) : 0;
      rdy_seen = readies();
      dd_seen = drain_done;
      chk("ready", 32'(rdy_seen), 32'(exp_rdy));
      chk("arb_valid", 32'(arb_valid), (m_hold >= 0) ? 1 : 0);
      chk("arb_sel", 32'(arb_sel), sel);
      chk("inflight", 32'(inflight), m_infl);
      chk("drain_done", 32'(drain_done), (m_drain && m_infl == 0) ? 1 : 0);
      m_infl = m_infl + (hs ? 1 : 0) - ((pipe_done && m_infl > 0) ? 1 : 0);
      if (exp_rdy != 0 && w >= 2) begin
         if (w == m_last) m_streak = (m_streak < MAX_STREAK) ? m_streak + 1 : MAX_STREAK;
         else begin
            m_last = w;
            m_streak = 1;
         end
      end
      if (m_drain) m_drain = drain_req;
      else if (drain_req && (m_hold < 0 || hs)) m_drain = 1;
      if (exp_rdy != 0) m_hold = w;
      else if (hs) m_hold = -1;
      @(negedge clk);
   endtask
   task automatic do_reset();
      rst = 1'b0;
      #1;
      model_reset();
      @(negedge clk);
      rst = 1'b1;
   endtask
   initial begin
      logic [3:0] seq37 [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
      rst = 1'b0;
      set_in(1, 1, 1, 1);
      {req_stall, dma_stall, rst_stall, drain_req, pipe_done, arb_ready} = '0;
      model_reset();
      #2;
      chk("rst_ready", 32'(readies()), 0);
      chk("rst_valid", 32'(arb_valid), 0);
      chk("rst_sel", 32'(arb_sel), 0);
      chk("rst_inflight", 32'(inflight), 0);
      chk("rst_drain_done", 32'(drain_done), 0);
      @(negedge clk);
      rst = 1'b1;
      // all four valid: rst_tb, rsp, req, dma, one grant per cycle
      arb_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("prio_seq", 32'(rdy_seen), 32'(seq37[i]));
         if (rdy_seen[0]) llc_rst_tb_valid = 1'b0;
         if (rdy_seen[1]) llc_rsp_in_valid = 1'b0;
         if (rdy_seen[2]) llc_req_in_valid = 1'b0;
         if (rdy_seen[3]) llc_dma_req_in_valid = 1'b0;
      end
      for (int i = 0; i < 8; i++) begin
         pipe_done = m_infl > 0;
         step();
      end
      pipe_done = 1'b0;
      // streak fairness from a clean state: req x4, dma x4, req x4
      do_reset();
      set_in(0, 0, 1, 1);
      for (int i = 0; i < 12; i++) begin
         pipe_done = m_infl > 0;
         step();
         chk("streak_seq", 32'(rdy_seen), (i < 4 || i >= 8) ? 32'h4 : 32'h8);
      end
      // held grant is stable while arb_ready is low, even as stalls change
      do_reset();
      set_in(0, 1, 0, 0);
      pipe_done = 1'b0;
      arb_ready = 1'b0;
      step();
      set_in(0, 0, 1, 0);
      req_stall = 1'b1;
      for (int i = 0; i < 5; i++) begin
         if (i == 2) req_stall = 1'b0;
         step();
         chk("hold_sel", 32'(arb_sel), 32'h2);
         chk("hold_ready", 32'(rdy_seen), 0);
      end
      arb_ready = 1'b1;
      step();
      chk("hold_release", 32'(rdy_seen), 32'h4);
      // in-flight limit: four admissions, then blocked until a retirement
      do_reset();
      set_in(0, 0, 1, 0);
      for (int i = 0; i < 7; i++) begin
         step();
         chk("limit_adm", 32'(rdy_seen[2]), (i < 4) ? 1 : 0);
      end
      pipe_done = 1'b1;
      step();
      chk("limit_pd_cycle", 32'(rdy_seen), 0);
      pipe_done = 1'b0;
      step();
      chk("limit_readmit", 32'(rdy_seen), 32'h4);
      // drain with two in flight
      do_reset();
      set_in(0, 0, 1, 0);
      step();
      step();
      set_in(0, 0, 0, 0);
      step();
      chk("drain_infl", 32'(inflight), 2);
      drain_req = 1'b1;
      set_in(0, 0, 1, 0);
      step();
      step();
      chk("drain_dd0", 32'(dd_seen), 0);
      pipe_done = 1'b1;
      step();
      pipe_done = 1'b0;
      step();
      chk("drain_dd1", 32'(dd_seen), 0);
      pipe_done = 1'b1;
      step();
      pipe_done = 1'b0;
      step();
      chk("drain_dd2", 32'(dd_seen), 1);
      drain_req = 1'b0;
      step();
      step();
      chk("drain_exit", 32'(rdy_seen), 32'h4);
      // reset while holding a grant with three in flight
      do_reset();
      set_in(0, 0, 1, 0);
      for (int i = 0; i < 4; i++) step();
      chk("pre_rst_valid", 32'(arb_valid), 1);
      chk("pre_rst_infl", 32'(inflight), 3);
      #2;
      rst = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(arb_valid), 0);
      chk("mid_rst_infl", 32'(inflight), 0);
      chk("mid_rst_ready", 32'(readies()), 0);
      set_in(0, 0, 0, 0);
      model_reset();
      @(negedge clk);
      rst = 1'b1;
      step();
      chk("post_rst_ready", 32'(rdy_seen), 0);
      // random traffic against the model
      for (int i = 0; i < 3000; i++) begin
         set_in($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 4,
                $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7);
         {req_stall, dma_stall, rst_stall} = {$urandom_range(0, 3) == 0,
                                              $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0};
         arb_ready = $urandom_range(0, 9) < 7;
         if ($urandom_range(0, 99) < 3) drain_req = ~drain_req;
         pipe_done = (m_infl > 0 || !(m_hold >= 0 && arb_ready)) ? $urandom_range(0, 9) < 4 : 1'b0;
         step();
      end
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
